// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler sharing one registered two-stage adder among N requesters.
// Results are queued with their requester ID in a credit-gated show-ahead FIFO.
module adder_rr_scheduler #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int IDW   = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   a_in,
  input  logic [N*W-1:0]   b_in,
  output logic [N-1:0]     gnt,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W:0]       res_data,
  output logic [IDW-1:0]   res_id,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] ptr_next;
  logic           gnt_any;
  logic [IDW-1:0] gnt_idx;
  logic           issue_ok;
  logic [CW:0]    credit_used;

  logic           s1_v;
  logic [W-1:0]   s1_a;
  logic [W-1:0]   s1_b;
  logic [IDW-1:0] s1_id;
  logic [W:0]     s1_sum;

  logic [W:0]     mem_data [DEPTH];
  logic [IDW-1:0] mem_id   [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [W:0]     hold_data;
  logic [IDW-1:0] hold_id;
  logic           push;
  logic           pop;

  // A result in stage 1 already owns a FIFO slot; a same-cycle pop is not credited.
  assign credit_used = {1'b0, count} + {{CW{1'b0}}, s1_v};
  assign issue_ok    = credit_used < (CW+1)'(DEPTH);

  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (issue_ok && !rst && !gnt_any && req[(int'(ptr) + k) % N]) begin
        gnt[(int'(ptr) + k) % N] = 1'b1;
        gnt_any                  = 1'b1;
        gnt_idx                  = IDW'((int'(ptr) + k) % N);
      end
    end
  end

  assign ptr_next = (gnt_idx == IDW'(N-1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      s1_v  <= 1'b0;
      s1_a  <= '0;
      s1_b  <= '0;
      s1_id <= '0;
    end else begin
      s1_v <= gnt_any;
      if (gnt_any) begin
        ptr   <= ptr_next;
        s1_a  <= a_in[gnt_idx*W +: W];
        s1_b  <= b_in[gnt_idx*W +: W];
        s1_id <= gnt_idx;
      end
    end
  end

  assign s1_sum = {1'b0, s1_a} + {1'b0, s1_b};

  // Result port: a transfer happens on a cycle where res_valid && res_ready;
  // res_valid never depends on res_ready, and res_ready with res_valid low is ignored.
  assign push = s1_v;
  assign pop  = res_valid && res_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= s1_sum;
      mem_id[wr_ptr]   <= s1_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      hold_data <= '0;
      hold_id   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        hold_data <= mem_data[rd_ptr];
        hold_id   <= mem_id[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // When empty, the last popped head stays visible.
  assign res_valid = (count != '0);
  assign res_data  = res_valid ? mem_data[rd_ptr] : hold_data;
  assign res_id    = res_valid ? mem_id[rd_ptr]   : hold_id;
  assign busy      = s1_v || res_valid;

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Bench for adder_rr_scheduler: per-scenario tasks with inline checks and a
// result scoreboard fed at grant time and drained when the FIFO pops.
module tb_adder_rr_scheduler;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int IDW   = 2;
  localparam int RW    = IDW + W + 1;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   a_in;
  logic [N*W-1:0]   b_in;
  logic [N-1:0]     gnt;
  logic             res_valid;
  logic             res_ready;
  logic [W:0]       res_data;
  logic [IDW-1:0]   res_id;
  logic             busy;

  logic [W-1:0]     a_v [N];
  logic [W-1:0]     b_v [N];
  logic [RW-1:0]    exp_q[$];
  logic [RW-1:0]    sb_exp;
  int               tests_run;
  int               fails;

  adder_rr_scheduler #(.N(N), .W(W), .DEPTH(DEPTH), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .gnt(gnt),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id), .busy(busy)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // scoreboard: compare every popped head against the oldest expected result
  always @(negedge clk) begin
    #2;
    if (!rst && res_valid && res_ready) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_extra: got id=%0d data=%0h, expected no result", res_id, res_data);
      end else begin
        sb_exp = exp_q.pop_front();
        if ({res_id, res_data} !== sb_exp) begin
          fails++;
          $display("FAIL sb_result: got id=%0d data=%0h, expected id=%0d data=%0h",
                   res_id, res_data, sb_exp[RW-1 -: IDW], sb_exp[W:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_ops();
    for (int i = 0; i < N; i++) begin
      a_in[i*W +: W] = a_v[i];
      b_in[i*W +: W] = b_v[i];
    end
  endtask

  task automatic random_ops();
    for (int i = 0; i < N; i++) begin
      a_v[i] = W'($urandom_range(1, 255));
      b_v[i] = W'($urandom_range(0, 255));
    end
    apply_ops();
  endtask

  task automatic push_exp(input int id);
    exp_q.push_back({IDW'(id), {1'b0, a_v[id]} + {1'b0, b_v[id]}});
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    res_ready = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    res_ready = 1'b1;
    while ((exp_q.size() != 0 || busy) && n < 40) begin
      @(negedge clk);
      #3;
      n++;
    end
    tests_run++;
    if (exp_q.size() != 0 || busy) begin
      fails++;
      $display("FAIL drain: got %0d pending busy=%b, expected 0 pending busy=0", exp_q.size(), busy);
    end
  endtask

  // scenarios
  task automatic test_reset();
    tick();
    req = '1;
    random_ops();
    #1;
    tests_run++; if (gnt !== 4'b0000) begin fails++; $display("FAIL rst_gnt: got %b expected 0000", gnt); end
    tests_run++; if (res_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b expected 0", res_valid); end
    tests_run++; if (res_data !== 9'h000) begin fails++; $display("FAIL rst_data: got %h expected 000", res_data); end
    tests_run++; if (res_id !== 2'd0) begin fails++; $display("FAIL rst_id: got %0d expected 0", res_id); end
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b expected 0", busy); end
    tick();
    rst = 1'b0;
    req = '0;
  endtask

  task automatic test_single();
    pulse_reset();
    tick();
    res_ready = 1'b1;
    a_v[0] = 8'd3;
    b_v[0] = 8'd4;
    apply_ops();
    req = 4'b0001;
    #1;
    tests_run++; if (gnt !== 4'b0001) begin fails++; $display("FAIL single_gnt: got %b expected 0001", gnt); end
    push_exp(0);
    tick();
    req = '0;
    #1;
    tests_run++; if (res_valid !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL single_t1: got valid=%b busy=%b expected valid=0 busy=1", res_valid, busy); end
    tick();
    #1;
    tests_run++; if (res_valid !== 1'b1 || res_data !== 9'd7 || res_id !== 2'd0) begin fails++; $display("FAIL single_t2: got valid=%b data=%0d id=%0d expected valid=1 data=7 id=0", res_valid, res_data, res_id); end
    tick();
    #1;
    tests_run++; if (busy !== 1'b0 || res_valid !== 1'b0) begin fails++; $display("FAIL single_idle: got busy=%b valid=%b expected 0 0", busy, res_valid); end
    tests_run++; if (res_data !== 9'd7) begin fails++; $display("FAIL single_hold: got %0d expected 7", res_data); end
  endtask

  task automatic test_all_requesters();
    pulse_reset();
    res_ready = 1'b1;
    random_ops();
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 0) req = 4'b1111;
      else if (k <= 4) req[k-1] = 1'b0;
      #1;
      if (k < 4) begin
        tests_run++;
        if (gnt !== (4'b0001 << k)) begin fails++; $display("FAIL all_gnt%0d: got %b expected %b", k, gnt, 4'b0001 << k); end
        push_exp(k);
      end
      if (k >= 2) begin
        tests_run++;
        if (res_valid !== 1'b1 || res_id !== IDW'(k-2)) begin fails++; $display("FAIL all_res%0d: got valid=%b id=%0d expected valid=1 id=%0d", k, res_valid, res_id, k-2); end
      end
    end
    tick();
    req = 4'b1111;
    #1;
    tests_run++; if (gnt !== 4'b0001) begin fails++; $display("FAIL all_ptr_wrap: got %b expected 0001", gnt); end
    push_exp(0);
    tick();
    req = '0;
    drain();
  endtask

  task automatic test_wrap();
    pulse_reset();
    res_ready = 1'b1;
    random_ops();
    tick();
    req = 4'b0100;
    #1;
    tests_run++; if (gnt !== 4'b0100) begin fails++; $display("FAIL wrap_g2: got %b expected 0100", gnt); end
    push_exp(2);
    tick();
    req = 4'b1001;
    #1;
    tests_run++; if (gnt !== 4'b1000) begin fails++; $display("FAIL wrap_g3: got %b expected 1000", gnt); end
    push_exp(3);
    tick();
    req = 4'b0001;
    #1;
    tests_run++; if (gnt !== 4'b0001) begin fails++; $display("FAIL wrap_g0: got %b expected 0001", gnt); end
    push_exp(0);
    tick();
    req = '0;
    drain();
  endtask

  task automatic test_backpressure();
    logic [N-1:0] exp_g [6];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
    pulse_reset();
    res_ready = 1'b0;
    random_ops();
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c == 0) req = 4'b1111;
      #1;
      tests_run++;
      if (gnt !== exp_g[c]) begin fails++; $display("FAIL bp_gnt%0d: got %b expected %b", c, gnt, exp_g[c]); end
      if (c < 4) push_exp(c);
    end
    tests_run++; if (res_valid !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL bp_full: got valid=%b busy=%b expected 1 1", res_valid, busy); end
    tick();
    res_ready = 1'b1;
    #1;
    tests_run++; if (gnt !== 4'b0000) begin fails++; $display("FAIL bp_pop_nocredit: got %b expected 0000", gnt); end
    tick();
    res_ready = 1'b0;
    #1;
    tests_run++; if (gnt !== 4'b0001) begin fails++; $display("FAIL bp_refill: got %b expected 0001", gnt); end
    push_exp(0);
    tick();
    #1;
    tests_run++; if (gnt !== 4'b0000) begin fails++; $display("FAIL bp_s1_credit: got %b expected 0000", gnt); end
    tick();
    #1;
    tests_run++; if (gnt !== 4'b0000) begin fails++; $display("FAIL bp_full_again: got %b expected 0000", gnt); end
    tick();
    req = '0;
    drain();
  endtask

  task automatic test_arith();
    logic [W-1:0] va [3];
    logic [W-1:0] vb [3];
    logic [W:0]   vs [3];
    va = '{8'd255, 8'd255, 8'd0};
    vb = '{8'd1,   8'd255, 8'd0};
    vs = '{9'h100, 9'h1FE, 9'h000};
    for (int i = 0; i < 3; i++) begin
      tick();
      res_ready = 1'b1;
      a_v[i+1] = va[i];
      b_v[i+1] = vb[i];
      apply_ops();
      req = 4'b0001 << (i + 1);
      #1;
      tests_run++;
      if (gnt !== (4'b0001 << (i + 1))) begin fails++; $display("FAIL arith_gnt%0d: got %b expected %b", i, gnt, 4'b0001 << (i + 1)); end
      push_exp(i + 1);
      tick();
      req = '0;
      tick();
      #1;
      tests_run++;
      if (res_valid !== 1'b1 || res_data !== vs[i]) begin fails++; $display("FAIL arith_sum%0d: got valid=%b data=%h expected valid=1 data=%h", i, res_valid, res_data, vs[i]); end
    end
    drain();
  endtask

  task automatic test_reset_midop();
    logic [W:0] head;
    pulse_reset();
    res_ready = 1'b0;
    random_ops();
    head = {1'b0, a_v[0]} + {1'b0, b_v[0]};
    tick(); req = 4'b0111; #1;
    tests_run++; if (gnt !== 4'b0001) begin fails++; $display("FAIL mid_g0: got %b expected 0001", gnt); end
    tick(); req = 4'b0110; #1;
    tests_run++; if (gnt !== 4'b0010) begin fails++; $display("FAIL mid_g1: got %b expected 0010", gnt); end
    tick(); req = 4'b0100; #1;
    tests_run++; if (gnt !== 4'b0100) begin fails++; $display("FAIL mid_g2: got %b expected 0100", gnt); end
    tick(); req = '0; #1;
    tests_run++; if (res_valid !== 1'b1 || res_data !== head || busy !== 1'b1) begin fails++; $display("FAIL mid_pre: got valid=%b data=%h busy=%b expected 1 %h 1", res_valid, res_data, busy, head); end
    #2;
    rst = 1'b1;
    req = 4'b1010;
    exp_q.delete();
    #1;
    tests_run++; if (gnt !== 4'b0000) begin fails++; $display("FAIL mid_rst_gnt: got %b expected 0000", gnt); end
    tests_run++; if (res_valid !== 1'b0 || res_data !== 9'h000 || res_id !== 2'd0 || busy !== 1'b0) begin fails++; $display("FAIL mid_rst_out: got valid=%b data=%h id=%0d busy=%b expected all 0", res_valid, res_data, res_id, busy); end
    tick();
    rst = 1'b0;
    res_ready = 1'b1;
    #1;
    tests_run++; if (gnt !== 4'b0010) begin fails++; $display("FAIL mid_first_gnt: got %b expected 0010", gnt); end
    push_exp(1);
    tick();
    req = '0;
    drain();
  endtask

  initial begin
    tests_run = 0;
    fails     = 0;
    rst       = 1'b0;
    req       = '0;
    a_in      = '0;
    b_in      = '0;
    res_ready = 1'b0;
    #1;
    rst = 1'b1;
    test_reset();
    test_single();
    test_all_requesters();
    test_wrap();
    test_backpressure();
    test_arith();
    test_reset_midop();
    tests_run++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL final_queue: got %0d pending expected 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
